// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADC scan scheduler and its FIFO consumers.
//   - scan_state_e : scheduler FSM states
//   - ch_width()   : channel tag width, at least 1 bit
//   - acc_width()  : accumulator width that holds 2^osr_log2 samples without overflow
//   - fifo_wdata layout {channel, averaged result}: result at bit 0,
//     channel tag starting at wdata_ch_lsb(DATA_W)
package adc_scan_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEL      = 3'd1,
      WAIT_RDY = 3'd2,
      START    = 3'd3,
      CONV     = 3'd4,
      WRITE    = 3'd5,
      DONE     = 3'd6
   } scan_state_e;

   localparam int WDATA_RESULT_LSB = 0;

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int acc_width(input int data_w, input int osr_log2);
      return data_w + osr_log2;
   endfunction

   function automatic int wdata_ch_lsb(input int data_w);
      return WDATA_RESULT_LSB + data_w;
   endfunction

endpackage

// File: rtl/lowest_set_picker.sv
// Combinational priority encoder: index of the lowest set bit of mask_i.
// Ports:
//   mask_i : remaining channel mask
//   idx_o  : index of lowest set bit (0 when mask is empty)
//   none_o : 1 when no bits remain
module lowest_set_picker #(
   parameter int N  = 4,
   parameter int CW = 2
) (
   input  logic [N-1:0]  mask_i,
   output logic [CW-1:0] idx_o,
   output logic          none_o
);

   // Scan from the top down so the lowest set bit is the last to write idx_o.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_i[i]) idx_o = CW'(i);
      end
   end

   assign none_o = ~|mask_i;

endmodule

// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: on each rtc_trig, walks the latched channel mask from
// the lowest channel up, powers the ADC, averages 2^OSR_LOG2 conversions per
// channel and pushes {channel, average} into the sample FIFO.
//
// Optional feature macro: ADC_SCAN_TIMEOUT_EN
//   defined   : WAIT_RDY/CONV waits are bounded by TIMEOUT_CYCLES; expiry
//               abandons the channel and sets timeout_err.
//   undefined : waits are unbounded, timeout_err is tied 0.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rtc_trig        : scan request pulse
//   ch_mask         : channel enable mask, latched at scan start
//   adc_ready       : ADC powered and ready
//   adc_done        : conversion complete, adc_data valid
//   adc_data        : conversion result
//   adc_enable      : ADC power/enable
//   adc_start       : one-cycle conversion start
//   adc_ch_sel      : mux channel select
//   fifo_full       : sample FIFO full
//   fifo_write_en   : one-cycle FIFO push
//   fifo_wdata      : {channel, averaged result}
//   busy            : scan in progress
//   scan_done       : one-cycle end-of-scan pulse
//   status_clr      : clears sticky flags
//   overflow        : sticky, result dropped on fifo_full
//   trig_missed     : sticky, rtc_trig while busy
//   timeout_err     : sticky, ADC wait timed out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for rtc_trig
// SEL      | pick lowest remaining channel, or finish if none left
// WAIT_RDY | ADC enabled, waiting for adc_ready
// START    | adc_start pulse
// CONV     | waiting for adc_done, accumulating samples
// WRITE    | averaged result presented to the FIFO (or dropped)
// DONE     | adc_enable low, scan_done pulse
module adc_scan_scheduler
   import adc_scan_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DATA_W         = 12,
   parameter int OSR_LOG2       = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int CH_W          = ch_width(NUM_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rtc_trig,
   input  logic [NUM_CH-1:0]      ch_mask,
   input  logic                   adc_ready,
   input  logic                   adc_done,
   input  logic [DATA_W-1:0]      adc_data,
   output logic                   adc_enable,
   output logic                   adc_start,
   output logic [CH_W-1:0]        adc_ch_sel,
   input  logic                   fifo_full,
   output logic                   fifo_write_en,
   output logic [CH_W+DATA_W-1:0] fifo_wdata,
   output logic                   busy,
   output logic                   scan_done,
   input  logic                   status_clr,
   output logic                   overflow,
   output logic                   trig_missed,
   output logic                   timeout_err
);

   localparam int ACC_W  = acc_width(DATA_W, OSR_LOG2);
   localparam int CNT_W  = OSR_LOG2 + 1;
   localparam int CH_LSB = wdata_ch_lsb(DATA_W);
   localparam logic [CNT_W-1:0] NUM_CONV = CNT_W'(1) << OSR_LOG2;

   scan_state_e             state_q, state_d;
   logic [NUM_CH-1:0]       mask_q, mask_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    en_q, en_d;
   logic                    start_q, start_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic                    we_q, we_d;
   logic [CH_W+DATA_W-1:0]  wdata_q, wdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;
   logic                    missed_q, missed_d;

   logic [CH_W-1:0]         pick_idx;
   logic                    pick_none;
   logic [ACC_W-1:0]        acc_sum;
   logic [DATA_W-1:0]       avg;
   logic [CNT_W-1:0]        cnt_inc;
   logic [NUM_CH-1:0]       clr_bit;
   logic                    ovf_set;

`ifdef ADC_SCAN_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic                    tmo_expire;
   logic                    abandon;
   logic                    tmo_err_q, tmo_err_d;
`endif

   // Picker looks at the next-cycle mask so adc_ch_sel is already valid
   // during the SEL cycle itself. While in SEL, mask_d equals mask_q.
   lowest_set_picker #(
      .N  (NUM_CH),
      .CW (CH_W)
   ) u_picker (
      .mask_i (mask_d),
      .idx_o  (pick_idx),
      .none_o (pick_none)
   );

   assign acc_sum = acc_q + ACC_W'(adc_data);
   assign avg     = DATA_W'(acc_sum >> OSR_LOG2);
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign clr_bit = NUM_CH'(1) << ch_q;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      ovf_set = 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
      abandon = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (rtc_trig) begin
               mask_d  = ch_mask;
               state_d = SEL;
            end
         end
         SEL: begin
            state_d = pick_none ? DONE : WAIT_RDY;
         end
         WAIT_RDY: begin
            if (adc_ready) state_d = START;
`ifdef ADC_SCAN_TIMEOUT_EN
            else if (tmo_expire) abandon = 1'b1;
`endif
         end
         START: begin
            state_d = CONV;
         end
         CONV: begin
            if (adc_done) begin
               acc_d = acc_sum;
               cnt_d = cnt_inc;
               if (cnt_inc == NUM_CONV) begin
                  state_d = WRITE;
                  // FIFO push/drop is decided here so it is registered
                  // and presented during the WRITE cycle.
                  if (fifo_full) begin
                     ovf_set = 1'b1;
                  end else begin
                     we_d = 1'b1;
                     wdata_d[WDATA_RESULT_LSB +: DATA_W] = avg;
                     wdata_d[CH_LSB +: CH_W]             = ch_q;
                  end
               end else begin
                  state_d = START;
               end
            end
`ifdef ADC_SCAN_TIMEOUT_EN
            else if (tmo_expire) abandon = 1'b1;
`endif
         end
         WRITE: begin
            mask_d  = mask_q & ~clr_bit;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SEL;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef ADC_SCAN_TIMEOUT_EN
      if (abandon) begin
         mask_d  = mask_q & ~clr_bit;
         acc_d   = '0;
         cnt_d   = '0;
         state_d = SEL;
      end
`endif

      ch_d     = (state_d == SEL) ? pick_idx : ch_q;
      start_d  = (state_d == START);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      // Enable rises with the first SEL of a non-empty scan and is held
      // across channels (including the final empty SEL) until DONE.
      en_d     = (state_d != IDLE) && (state_d != DONE) &&
                 ((mask_d != '0) || en_q);
      ovf_d    = ovf_set | (ovf_q & ~status_clr);
      missed_d = (rtc_trig && (state_q != IDLE)) | (missed_q & ~status_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         start_q  <= 1'b0;
         ch_q     <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         start_q  <= start_d;
         ch_q     <= ch_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         missed_q <= missed_d;
      end
   end

`ifdef ADC_SCAN_TIMEOUT_EN
   // Reloads on every entry to a wait state; expiry is the last of
   // TIMEOUT_CYCLES cycles spent waiting.
   assign tmo_expire = (tmo_q == TMO_W'(1));

   always_comb begin
      tmo_d = (tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q;
      if (((state_d == WAIT_RDY) && (state_q != WAIT_RDY)) ||
          ((state_d == CONV) && (state_q != CONV))) begin
         tmo_d = TMO_W'(TIMEOUT_CYCLES);
      end
      tmo_err_d = abandon | (tmo_err_q & ~status_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign adc_enable    = en_q;
   assign adc_start     = start_q;
   assign adc_ch_sel    = ch_q;
   assign fifo_write_en = we_q;
   assign fifo_wdata    = wdata_q;
   assign busy          = busy_q;
   assign scan_done     = done_q;
   assign overflow      = ovf_q;
   assign trig_missed   = missed_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
module tb_adc_scan_scheduler;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 12;
   localparam int OSR_LOG2 = 2;
   localparam int CH_W = 2;
   localparam int NCONV = 4;

   logic                   clk = 1'b0;
   logic                   rst, rtc_trig, adc_ready, adc_done, fifo_full, status_clr;
   logic [NUM_CH-1:0]      ch_mask;
   logic [DATA_W-1:0]      adc_data;
   logic                   adc_enable, adc_start, fifo_write_en, busy, scan_done;
   logic                   overflow, trig_missed, timeout_err;
   logic [CH_W-1:0]        adc_ch_sel;
   logic [CH_W+DATA_W-1:0] fifo_wdata;

   always #5 clk = ~clk;

   adc_scan_scheduler #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2), .TIMEOUT_CYCLES(1024)
   ) dut (
      .clk(clk), .rst(rst), .rtc_trig(rtc_trig), .ch_mask(ch_mask),
      .adc_ready(adc_ready), .adc_done(adc_done), .adc_data(adc_data),
      .adc_enable(adc_enable), .adc_start(adc_start), .adc_ch_sel(adc_ch_sel),
      .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_wdata(fifo_wdata),
      .busy(busy), .scan_done(scan_done), .status_clr(status_clr),
      .overflow(overflow), .trig_missed(trig_missed), .timeout_err(timeout_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [CH_W+DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0]      samp_q[$];
   logic [DATA_W-1:0]      dir_q[$];
   int                     exp_ch_q[$];
   int                     wr_cyc_q[$];
   int                     exp_done_cnt = 0;
   int                     done_cyc = -1;
   int                     t_trig = 0;
   int                     n_en = 0, n_start = 0, n_wr = 0;
   logic                   prev_en = 1'b0;
   logic                   en_before_done = 1'b0;
   bit                     adc_hold = 1'b0;
   bit                     rand_mode = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Reference model: channels are served lowest first; each one consumes
   // NCONV samples and yields their integer mean, unless the FIFO is full.
   task automatic model_scan(input logic [NUM_CH-1:0] m, input bit ff);
      int sum;
      logic [DATA_W-1:0] s;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m[c]) begin
            sum = 0;
            for (int k = 0; k < NCONV; k++) begin
               if (dir_q.size() > 0) s = dir_q.pop_front();
               else s = DATA_W'($urandom);
               samp_q.push_back(s);
               exp_ch_q.push_back(c);
               sum += int'(s);
            end
            if (!ff) exp_q.push_back({CH_W'(c), DATA_W'(sum / NCONV)});
         end
      end
      exp_done_cnt++;
   endtask

   task automatic trig(input logic [NUM_CH-1:0] m);
      ch_mask  = m;
      rtc_trig = 1'b1;
      t_trig   = cyc;
      @(negedge clk);
      rtc_trig = 1'b0;
      ch_mask  = NUM_CH'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (exp_done_cnt != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_done_cnt != 0) begin
         chk("scan_done_wait_expired", 64'(exp_done_cnt), 0);
         exp_done_cnt = 0;
      end
      repeat (2) @(negedge clk);
      chk("pending_writes", 64'(exp_q.size()), 0);
      chk("pending_samples", 64'(samp_q.size()), 0);
      chk("busy_idle", busy, 0);
      exp_q.delete();
      samp_q.delete();
      exp_ch_q.delete();
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      while (adc_start !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (adc_start !== 1'b1) chk("adc_start_wait_expired", 0, 1);
   endtask

   task automatic pulse_clr();
      status_clr = 1'b1;
      @(negedge clk);
      status_clr = 1'b0;
   endtask

   // ADC behaviour: conversion completes 1+delay cycles after adc_start.
   initial begin
      int dly;
      adc_done = 1'b0;
      adc_data = '0;
      forever begin
         @(negedge clk);
         adc_done = 1'b0;
         if (adc_start === 1'b1 && !adc_hold) begin
            if (samp_q.size() == 0) begin
               chk("adc_start_unexpected", 1, 0);
            end else begin
               chk("adc_ch_sel", adc_ch_sel, 64'(exp_ch_q.pop_front()));
               if (rand_mode) begin
                  // spurious completion during START must be ignored
                  adc_done = 1'($urandom_range(0, 1));
                  adc_data = DATA_W'($urandom);
               end
               dly = rand_mode ? $urandom_range(0, 3) : 0;
               @(negedge clk);
               adc_done = 1'b0;
               repeat (dly) @(negedge clk);
               adc_data = samp_q.pop_front();
               adc_done = 1'b1;
            end
         end
      end
   end

   initial begin
      adc_ready = 1'b1;
      forever begin
         @(negedge clk);
         adc_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor: pops expected FIFO words and scan completions.
   initial begin
      forever begin
         @(negedge clk);
         if (adc_enable === 1'b1) n_en++;
         if (adc_start === 1'b1) n_start++;
         if (fifo_write_en === 1'b1) begin
            n_wr++;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write got=%h expected=none", fifo_wdata);
            end else begin
               chk("fifo_wdata", fifo_wdata, exp_q.pop_front());
            end
         end
         if (scan_done === 1'b1) begin
            done_cyc = cyc;
            en_before_done = prev_en;
            chk("enable_at_done", adc_enable, 0);
            chk("busy_at_done", busy, 1);
            if (exp_done_cnt == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_scan_done got=1 expected=0");
            end else begin
               exp_done_cnt--;
            end
         end
         prev_en = adc_enable;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_CH-1:0] m;
      bit ff;
      rst = 1'b1; rtc_trig = 1'b0; ch_mask = '0; fifo_full = 1'b0; status_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {adc_enable, adc_start, adc_ch_sel, fifo_write_en, fifo_wdata,
                            busy, scan_done, overflow, trig_missed, timeout_err}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: directed averaging, latency, enable falls with scan_done
      wr_cyc_q.delete();
      dir_q = {12'd100, 12'd102, 12'd104, 12'd106, 12'd200, 12'd200, 12'd200, 12'd200};
      model_scan(4'b0101, 1'b0);
      trig(4'b0101);
      wait_idle(500);
      chk("t1_write_count", 64'(wr_cyc_q.size()), 2);
      if (wr_cyc_q.size() > 0) chk("t1_latency", 64'(wr_cyc_q[0] - t_trig), 11);
      chk("t1_enable_before_done", en_before_done, 1);

      // Test 2: empty mask
      n_en = 0; n_start = 0; n_wr = 0;
      model_scan(4'b0000, 1'b0);
      trig(4'b0000);
      wait_idle(50);
      chk("t2_done_latency", 64'(done_cyc - t_trig), 2);
      chk("t2_enable_cycles", 64'(n_en), 0);
      chk("t2_start_cycles", 64'(n_start), 0);
      chk("t2_write_cycles", 64'(n_wr), 0);

      // Test 3: FIFO full drops the result and sets sticky overflow
      fifo_full = 1'b1;
      n_wr = 0;
      model_scan(4'b0001, 1'b1);
      trig(4'b0001);
      wait_idle(500);
      chk("t3_write_cycles", 64'(n_wr), 0);
      chk("t3_overflow", overflow, 1);
      repeat (3) @(negedge clk);
      chk("t3_overflow_held", overflow, 1);
      pulse_clr();
      chk("t3_overflow_clr", overflow, 0);
      fifo_full = 1'b0;

      // Test 4: trigger during CONV is flagged, not queued
      chk("t4_missed_pre", trig_missed, 0);
      wr_cyc_q.delete();
      model_scan(4'b0010, 1'b0);
      trig(4'b0010);
      wait_start(50);
      @(negedge clk);
      trig(4'b1111);
      wait_idle(500);
      repeat (20) @(negedge clk);
      chk("t4_trig_missed", trig_missed, 1);
      chk("t4_write_count", 64'(wr_cyc_q.size()), 1);

      // Test 5: reset in CONV on channel 1, then a clean rescan
      adc_hold = 1'b1;
      trig(4'b0110);
      wait_start(50);
      @(negedge clk);
      chk("t5_ch_before_rst", adc_ch_sel, 1);
      chk("t5_busy_before_rst", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_outputs_after_rst", {adc_enable, adc_start, adc_ch_sel, fifo_write_en, fifo_wdata,
                                   busy, scan_done, overflow, trig_missed, timeout_err}, 0);
      rst = 1'b0;
      adc_hold = 1'b0;
      @(negedge clk);
      wr_cyc_q.delete();
      model_scan(4'b0110, 1'b0);
      trig(4'b0110);
      wait_idle(500);
      chk("t5_write_count", 64'(wr_cyc_q.size()), 2);

      // Randomized scans: random masks, data, ready and conversion delays
      rand_mode = 1'b1;
      for (int s = 0; s < 25; s++) begin
         m  = NUM_CH'($urandom);
         ff = ($urandom_range(0, 3) == 0);
         pulse_clr();
         fifo_full = ff;
         model_scan(m, ff);
         trig(m);
         wait_idle(3000);
         chk("rand_overflow", overflow, 64'(ff && (m != '0)));
         chk("rand_trig_missed", trig_missed, 0);
         chk("rand_timeout_err", timeout_err, 0);
         fifo_full = 1'b0;
      end
      rand_mode = 1'b0;

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the shared sensor ADC across NUM_CH soil/ambient channels on each RTC trigger. Per channel it:
- selects the mux channel,
- powers the ADC and waits for ready,
- runs 2^OSR_LOG2 conversions and averages them,
- pushes one tagged result into the sample FIFO read by the APB side.

It sits between the RTC, the ADC macro and the sample FIFO, and supersedes single-channel wrapper sequencing.

Parameters:
NUM_CH, 4, number of ADC mux channels scanned
DATA_W, 12, ADC result width
OSR_LOG2, 2, log2 of conversions averaged per channel (0 = no averaging)
CH_W, $clog2(NUM_CH) (min 1), channel tag width (localparam)
TIMEOUT_CYCLES, 1024, wait limit for adc_ready/adc_done (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rtc_trig  in  1  scan request pulse
ch_mask  in  NUM_CH  channel enable mask, latched at scan start
adc_ready  in  1  ADC powered and ready
adc_done  in  1  conversion complete, adc_data valid this cycle
adc_data  in  DATA_W  conversion result
adc_enable  out  1  ADC power/enable
adc_start  out  1  one-cycle conversion start pulse
adc_ch_sel  out  CH_W  mux channel select
fifo_full  in  1  sample FIFO full
fifo_write_en  out  1  one-cycle FIFO push
fifo_wdata  out  CH_W+DATA_W  {channel, averaged result}
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse at end of scan
status_clr  in  1  clears sticky flags
overflow  out  1  sticky: result dropped due to fifo_full
trig_missed  out  1  sticky: rtc_trig arrived while busy
timeout_err  out  1  sticky: ADC wait timed out (tied 0 without feature)

Behaviour:
- Synchronous reset, active-high, clocked by clk.
- Reset takes priority at any point, including mid-scan:
  - state returns to IDLE;
  - all outputs go to 0;
  - accumulator, sample counter and latched mask are cleared.
- All outputs are registered.
- States: IDLE, SEL, WAIT_RDY, START, CONV, WRITE, DONE.
- IDLE:
  - rtc_trig=1 latches ch_mask and goes to SEL next cycle.
  - busy=1 from that cycle until DONE exits.
- rtc_trig while not in IDLE sets trig_missed and does not queue a scan.
- SEL:
  - picks the lowest set bit of the remaining mask and drives adc_ch_sel.
  - adc_enable=1 from the first SEL through DONE (held across channels).
  - If no bits remain, go to DONE.
- WAIT_RDY: leaves to START on the first cycle adc_ready=1.
- START: adc_start=1 for exactly one cycle, then CONV.
- CONV:
  - on adc_done=1, adds adc_data into an accumulator of width DATA_W+OSR_LOG2;
  - increments the sample counter;
  - if count < 2^OSR_LOG2, returns to START; else goes to WRITE.
- WRITE:
  - result = accumulator >> OSR_LOG2, truncating with no rounding.
  - If fifo_full=0: fifo_write_en=1 for one cycle and fifo_wdata={ch, result}.
  - If fifo_full=1: result is dropped, overflow is set, no stall.
  - Either way: clear that mask bit, clear the accumulator and counter, go to SEL.
- DONE:
  - adc_enable=0, scan_done=1 for one cycle, busy=0 next, back to IDLE.
  - A mask of 0 gives SEL→DONE with no ADC activity: scan_done 2 cycles after rtc_trig.
- adc_ch_sel is stable from SEL through WRITE of that channel.
- adc_done outside CONV is ignored.
- Sticky flags:
  - cleared by status_clr;
  - a set event in the same cycle as status_clr wins.
- Latency: with adc_ready already high and single-cycle conversions, rtc_trig → first fifo_write_en = 3 + 2·2^OSR_LOG2 cycles.

Optional Feature:
ADC_SCAN_TIMEOUT_EN
- Defined:
  - A down-counter loads TIMEOUT_CYCLES on entry to WAIT_RDY or CONV.
  - Expiry sets timeout_err, abandons the channel with no FIFO write, clears its mask bit and returns to SEL.
- Undefined:
  - Waits are unbounded.
  - timeout_err is constant 0 and no counter logic is present.

Decomposition:
- Shared package adc_scan_pkg holds:
  - the state enum;
  - the CH_W and ACC_W derivation functions;
  - the fifo_wdata field offsets, also used by the APB FIFO reader.
- One sub-module, lowest_set_picker: a combinational priority encoder from the remaining mask to the channel index plus a none-left flag.
- The accumulator and FSM stay in the top level.

Test Plan:
1. Mask=4'b0101, OSR_LOG2=2, adc_data 100,102,104,106 then 200×4, each adc_done one cycle after adc_start → two FIFO writes, {0,103} then {2,200}, then one scan_done pulse with adc_enable falling the same cycle.
2. Mask=0, rtc_trig pulse → scan_done 2 cycles later; adc_enable, adc_start and fifo_write_en never assert.
3. fifo_full=1 throughout a mask=4'b0001 scan → no fifo_write_en, overflow=1 and held; status_clr pulse → overflow=0.
4. rtc_trig re-pulsed during CONV → trig_missed=1; only one scan completes.
5. rst asserted in CONV on channel 1 → all outputs 0 next cycle; a fresh rtc_trig restarts from the lowest masked channel with the accumulator at 0.
6. With ADC_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=16, adc_ready held 0 → timeout_err=1 after 16 cycles in WAIT_RDY; the channel is skipped and the next masked channel proceeds.
